// File: rtl/intc_arbiter.sv
// Interrupt controller: edge-latched, maskable requests arbitrated by priority table or round-robin,
// presented on a req/ack handshake. Optional ack timeout enabled with `define INTC_TIMEOUT_EN.
module intc_arbiter #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned PW    = $clog2(N_IRQ)
`ifdef INTC_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic [N_IRQ-1:0]    mask,
  input  logic                mode,
  input  logic                prio_load,
  input  logic [N_IRQ*PW-1:0] prio_table,
  input  logic                ack,
  output logic                irq_req,
  output logic [PW-1:0]       irq_id,
  output logic [N_IRQ-1:0]    irq_grant
`ifdef INTC_TIMEOUT_EN
  , output logic              irq_timeout
`endif
);

  localparam int unsigned SW = PW + 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e             state_q;
  logic [N_IRQ-1:0]   irq_prev_q;
  logic [N_IRQ-1:0]   pending_q;
  logic [N_IRQ-1:0]   pending_d;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   clr_vec;
  logic [N_IRQ-1:0]   eligible;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      table_q [N_IRQ];
  logic               irq_req_q;
  logic [PW-1:0]      irq_id_q;
  logic [N_IRQ-1:0]   irq_grant_q;
  logic [PW-1:0]      id_inc;

  logic               prio_hit;
  logic [PW-1:0]      prio_win;
  logic               rr_hit;
  logic [PW-1:0]      rr_win;
  logic [SW-1:0]      rr_sum;
  logic               win_hit;
  logic [PW-1:0]      win_id;

`ifdef INTC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]    to_cnt_q;
  logic               irq_timeout_q;
  assign irq_timeout = irq_timeout_q;
`endif

  assign irq_req   = irq_req_q;
  assign irq_id    = irq_id_q;
  assign irq_grant = irq_grant_q;

  // Pending update: a fresh edge in the ack cycle must survive the clear.
  always_comb begin
    rise     = irq_in & ~irq_prev_q;
    clr_vec  = '0;
    if (state_q == ST_BUSY && ack) clr_vec = irq_grant_q;
    pending_d = (pending_q & ~clr_vec) | rise;
    eligible  = pending_q & ~mask;
    id_inc    = (irq_id_q == PW'(N_IRQ - 1)) ? '0 : irq_id_q + PW'(1);
  end

  // Priority scan runs from the lowest rank last so rank 0 wins duplicates.
  always_comb begin
    prio_hit = 1'b0;
    prio_win = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (32'(table_q[k]) < N_IRQ && eligible[table_q[k]]) begin
        prio_hit = 1'b1;
        prio_win = table_q[k];
      end
    end
  end

  // Round-robin scan upward from rr_ptr with wrap; nearest offset wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    rr_sum = '0;
    for (int off = N_IRQ - 1; off >= 0; off--) begin
      rr_sum = {1'b0, rr_ptr_q} + SW'(off);
      if (rr_sum >= SW'(N_IRQ)) rr_sum = rr_sum - SW'(N_IRQ);
      if (eligible[rr_sum[PW-1:0]]) begin
        rr_hit = 1'b1;
        rr_win = rr_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    win_hit = mode ? rr_hit : prio_hit;
    win_id  = mode ? rr_win : prio_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      irq_req_q   <= 1'b0;
      irq_id_q    <= '0;
      irq_grant_q <= '0;
      for (int k = 0; k < N_IRQ; k++) table_q[k] <= PW'(k);
`ifdef INTC_TIMEOUT_EN
      to_cnt_q      <= '0;
      irq_timeout_q <= 1'b0;
`endif
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (prio_load) begin
        for (int k = 0; k < N_IRQ; k++) table_q[k] <= prio_table[k*PW +: PW];
      end
`ifdef INTC_TIMEOUT_EN
      irq_timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (win_hit) begin
            irq_req_q   <= 1'b1;
            irq_id_q    <= win_id;
            irq_grant_q <= N_IRQ'(1) << win_id;
            state_q     <= ST_BUSY;
`ifdef INTC_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (ack) begin
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
            irq_grant_q <= '0;
            rr_ptr_q    <= id_inc;
            state_q     <= ST_IDLE;
          end
`ifdef INTC_TIMEOUT_EN
          // Abandon the grant but leave it pending so it is retried later.
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            irq_req_q     <= 1'b0;
            irq_id_q      <= '0;
            irq_grant_q   <= '0;
            rr_ptr_q      <= id_inc;
            irq_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_arbiter.sv
// Bench for intc_arbiter (N_IRQ = 8): vector table plus hand sequences, grant order checked by scoreboard.
module tb_intc_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    irq_in;
  logic [N-1:0]    mask;
  logic            mode;
  logic            prio_load;
  logic [N*PW-1:0] prio_table;
  logic            ack;
  logic            irq_req;
  logic [PW-1:0]   irq_id;
  logic [N-1:0]    irq_grant;
`ifdef INTC_TIMEOUT_EN
  logic            irq_timeout;
`endif

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] sb_q[$];
  logic [PW-1:0] cur_exp = '0;
  logic          prev_req = 1'b0;

  typedef struct {
    logic          mode;
    logic [N-1:0]  mask;
    logic          load;
    logic [N*PW-1:0] tbl;
    logic [N-1:0]  raise;
    int            n;
    logic [3:0][PW-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  intc_arbiter #(
    .N_IRQ(N)
`ifdef INTC_TIMEOUT_EN
    , .TIMEOUT_CYC(10)
`endif
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .mode(mode),
    .prio_load(prio_load), .prio_table(prio_table), .ack(ack),
    .irq_req(irq_req), .irq_id(irq_id), .irq_grant(irq_grant)
`ifdef INTC_TIMEOUT_EN
    , .irq_timeout(irq_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and scoreboard any new grant at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (irq_req && !prev_req) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got id %0d expected no grant", irq_id);
        cur_exp = '0;
      end else begin
        cur_exp = sb_q.pop_front();
        chk("sb_grant_id", 32'(irq_id), 32'(cur_exp));
      end
    end else if (irq_req) begin
      chk("hold_id", 32'(irq_id), 32'(cur_exp));
    end else begin
      chk("idle_id", 32'(irq_id), 32'd0);
    end
    chk("grant_vec", 32'(irq_grant), irq_req ? 32'(N'(1) << cur_exp) : 32'd0);
    prev_req = irq_req;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!irq_req && k < 20) begin
      tick();
      k++;
    end
    chk("wait_req", 32'(irq_req), 32'd1);
  endtask

  task automatic service(input int n);
    for (int i = 0; i < n; i++) begin
      wait_req();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("ack_drop", 32'(irq_req), 32'd0);
    end
  endtask

  function automatic logic [N*PW-1:0] ident_tbl();
    logic [N*PW-1:0] t;
    for (int k = 0; k < N; k++) t[k*PW +: PW] = PW'(k);
    return t;
  endfunction

  function automatic vec_t mkv(input logic md, input logic [N-1:0] mk, input logic ld,
                               input logic [N*PW-1:0] tb, input logic [N-1:0] rs, input int n,
                               input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.mode = md; v.mask = mk; v.load = ld; v.tbl = tb; v.raise = rs; v.n = n;
    v.exp[0] = PW'(e0); v.exp[1] = PW'(e1); v.exp[2] = PW'(e2); v.exp[3] = PW'(e3);
    return v;
  endfunction

  initial begin
    logic [N*PW-1:0] t_id, t_swap, t_dup;
    t_id   = ident_tbl();
    t_swap = t_id;  t_swap[0 +: PW] = 3'd7;  t_swap[7*PW +: PW] = 3'd0;
    t_dup  = t_id;  t_dup[0 +: PW]  = 3'd3;  t_dup[1*PW +: PW]  = 3'd3;

    // rr_ptr enters this table at 6 (after the first hand sequence).
    vecs[0] = mkv(1'b0, 8'h00, 1'b1, t_swap, 8'h81, 2, 7, 0, 0, 0);
    vecs[1] = mkv(1'b0, 8'h00, 1'b1, t_dup,  8'h0A, 1, 3, 0, 0, 0);
    vecs[2] = mkv(1'b0, 8'h00, 1'b1, t_id,   8'h00, 1, 1, 0, 0, 0);
    vecs[3] = mkv(1'b0, 8'h01, 1'b0, t_id,   8'h41, 1, 6, 0, 0, 0);
    vecs[4] = mkv(1'b0, 8'h00, 1'b0, t_id,   8'h00, 1, 0, 0, 0, 0);
    vecs[5] = mkv(1'b1, 8'h00, 1'b0, t_id,   8'h4A, 3, 1, 3, 6, 0);
    vecs[6] = mkv(1'b1, 8'h00, 1'b0, t_id,   8'h03, 2, 0, 1, 0, 0);
    vecs[7] = mkv(1'b1, 8'h00, 1'b0, t_id,   8'h83, 3, 7, 0, 1, 0);
    vecs[8] = mkv(1'b1, 8'h00, 1'b0, t_id,   8'h24, 2, 2, 5, 0, 0);

    rst = 1'b1; irq_in = '0; mask = '0; mode = 1'b0;
    prio_load = 1'b0; prio_table = '0; ack = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_grant", 32'(irq_grant), 32'd0);
`ifdef INTC_TIMEOUT_EN
    chk("rst_timeout", 32'(irq_timeout), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Two-cycle latency, priority order, one idle cycle between grants.
    irq_in = 8'h24;
    sb_q.push_back(3'd2); sb_q.push_back(3'd5);
    tick();
    chk("lat_e0_req", 32'(irq_req), 32'd0);
    irq_in = '0;
    tick();
    chk("lat_e1_req", 32'(irq_req), 32'd1);
    chk("lat_e1_grant", 32'(irq_grant), 32'h04);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("gap_req", 32'(irq_req), 32'd0);
    tick();
    chk("next_req", 32'(irq_req), 32'd1);
    chk("next_id", 32'(irq_id), 32'd5);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    for (int v = 0; v < 9; v++) begin
      mode = vecs[v].mode;
      mask = vecs[v].mask;
      if (vecs[v].load) begin
        prio_table = vecs[v].tbl;
        prio_load  = 1'b1;
        tick();
        prio_load  = 1'b0;
      end
      irq_in = vecs[v].raise;
      for (int i = 0; i < vecs[v].n; i++) sb_q.push_back(vecs[v].exp[i]);
      tick();
      irq_in = '0;
      service(vecs[v].n);
      repeat (3) tick();
      chk($sformatf("v%0d_quiet", v), 32'(irq_req), 32'd0);
      chk($sformatf("v%0d_sb_empty", v), 32'(sb_q.size()), 32'd0);
    end

    // Masked channel latches but waits; unmasking grants without a new edge.
    mode = 1'b0; mask = 8'h10; irq_in = 8'h10;
    tick();
    irq_in = '0;
    repeat (4) begin
      tick();
      chk("masked_req", 32'(irq_req), 32'd0);
    end
    mask = '0;
    sb_q.push_back(3'd4);
    tick();
    chk("unmask_req", 32'(irq_req), 32'd1);
    chk("unmask_id", 32'(irq_id), 32'd4);
    mask = 8'h10; mode = 1'b1;
    repeat (3) begin
      tick();
      chk("busy_hold_req", 32'(irq_req), 32'd1);
      chk("busy_hold_id", 32'(irq_id), 32'd4);
    end
    mask = '0; mode = 1'b0;
    service(1);

    // New edge in the ack cycle keeps the channel pending.
    irq_in = 8'h08;
    sb_q.push_back(3'd3); sb_q.push_back(3'd3);
    tick();
    irq_in = '0;
    tick();
    chk("sw_req", 32'(irq_req), 32'd1);
    ack = 1'b1; irq_in = 8'h08;
    tick();
    ack = 1'b0; irq_in = '0;
    chk("sw_gap", 32'(irq_req), 32'd0);
    tick();
    chk("sw_regrant", 32'(irq_req), 32'd1);
    chk("sw_regrant_id", 32'(irq_id), 32'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("sw_cleared", 32'(irq_req), 32'd0);

    // ack while idle must not suppress the upcoming grant.
    irq_in = 8'h40;
    sb_q.push_back(3'd6);
    tick();
    irq_in = '0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_req", 32'(irq_req), 32'd1);
    chk("idle_ack_id", 32'(irq_id), 32'd6);
    tick();
    chk("idle_ack_hold", 32'(irq_req), 32'd1);
    service(1);

    // Reset mid-grant drops pending; a line high at release counts as an edge.
    irq_in = 8'h06;
    sb_q.push_back(3'd1);
    tick();
    irq_in = '0;
    tick();
    chk("pre_rst_id", 32'(irq_id), 32'd1);
    irq_in = 8'h40; rst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(irq_req), 32'd0);
    chk("mid_rst_id", 32'(irq_id), 32'd0);
    chk("mid_rst_grant", 32'(irq_grant), 32'd0);
    tick();
    rst = 1'b0;
    sb_q.push_back(3'd6);
    tick();
    chk("rel_e0_req", 32'(irq_req), 32'd0);
    tick();
    chk("rel_req", 32'(irq_req), 32'd1);
    chk("rel_id", 32'(irq_id), 32'd6);
    service(1);
    repeat (4) tick();
    chk("pending_lost", 32'(irq_req), 32'd0);
    irq_in = '0;
    tick();

`ifdef INTC_TIMEOUT_EN
    // Unacked grant times out after 10 cycles and is retried from pending.
    irq_in = 8'h04;
    sb_q.push_back(3'd2); sb_q.push_back(3'd2);
    tick();
    irq_in = '0;
    tick();
    chk("to_req", 32'(irq_req), 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk($sformatf("to_wait%0d_pulse", k), 32'(irq_timeout), 32'd0);
      chk($sformatf("to_wait%0d_req", k), 32'(irq_req), 32'd1);
    end
    tick();
    chk("to_pulse", 32'(irq_timeout), 32'd1);
    chk("to_req_drop", 32'(irq_req), 32'd0);
    tick();
    chk("to_pulse_end", 32'(irq_timeout), 32'd0);
    chk("to_retry_req", 32'(irq_req), 32'd1);
    chk("to_retry_id", 32'(irq_id), 32'd2);
    service(1);
    tick();
`endif

    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intc_arbiter.md
# intc_arbiter

Parametrised interrupt controller that latches edge-triggered requests from N_IRQ sources, masks them, and arbitrates one winner at a time using either a programmable priority table or round-robin polling. The winner is presented to the CPU-side logic with a req/ack handshake and stays stable until acknowledged. It replaces the fixed 4-channel controller at the same point in the design: between the peripheral interrupt lines and the core's interrupt entry logic.

## Interface
- N_IRQ, 8: number of interrupt channels; must be >= 2.
- PW, $clog2(N_IRQ): width of a channel index (derived; not overridden).
- TIMEOUT_CYC, 255: ack timeout in cycles; used only with INTC_TIMEOUT_EN.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt lines; a 0->1 transition sets the channel's pending bit.
- mask  in  N_IRQ  1 = channel blocked from arbitration; its pending bit still latches.
- mode  in  1  0 = priority-table arbitration, 1 = round-robin polling.
- prio_load  in  1  1 = load prio_table into the internal table on this edge.
- prio_table  in  N_IRQ*PW  slot k (bits k*PW +: PW) holds the channel index at rank k; rank 0 is highest.
- ack  in  1  CPU acknowledge for the current grant.
- irq_req  out  1  a grant is outstanding.
- irq_id  out  PW  index of the granted channel.
- irq_grant  out  N_IRQ  one-hot copy of irq_id; all zero when irq_req = 0.
- irq_timeout  out  1  single-cycle pulse on ack timeout; exists only with INTC_TIMEOUT_EN.

## Operation
- Edge detect: irq_prev <= irq_in every cycle. pending[i] is set when irq_in[i] & ~irq_prev[i].
- Eligible vector: pending & ~mask.
- FSM with two states, IDLE and BUSY:
  - IDLE: if any channel is eligible, register the winner into irq_id/irq_grant, set irq_req = 1, and go to BUSY. Otherwise stay in IDLE with outputs at zero.
  - BUSY: hold irq_id, irq_grant and irq_req unchanged. On ack = 1: clear pending[irq_id], drive irq_req/irq_grant/irq_id to 0, set rr_ptr = (irq_id + 1) mod N_IRQ, and go to IDLE.
- Priority mode: scan ranks 0..N_IRQ-1. The winner is the first rank whose channel is eligible. A channel absent from the table is never granted in this mode. With duplicate entries, the lowest rank wins.
- Round-robin mode: the winner is the first eligible channel found scanning upward from rr_ptr, wrapping from N_IRQ-1 to 0.
- The table loads on any cycle with prio_load = 1, in either state. The new table affects the next arbitration only.
- Changes to mode or mask while in BUSY do not withdraw or alter the current grant.
- ack in IDLE is ignored.
- Simultaneous set and clear on the same channel (a new edge in the ack cycle): set wins, so pending stays 1.

## Timing
- Reset values: irq_req = 0, irq_id = 0, irq_grant = 0, irq_timeout = 0, pending = 0, irq_prev = 0, rr_ptr = 0, state = IDLE, table slot k = k (identity).
- Because irq_prev resets to 0, a line that is high when reset is released counts as a rising edge.
- Latency: irq_in rises before edge E0 -> pending set at E0 -> irq_req = 1 after E1. That is 2 cycles from the input to the request.
- ack sampled at edge Ea -> irq_req = 0 after Ea. The earliest next grant is after Ea+1, giving one idle cycle between grants.
- Reset asserted mid-BUSY: outputs clear on that edge, and pending requests are lost.

## Configuration
- INTC_TIMEOUT_EN defined:
  - Adds a counter that runs in BUSY.
  - If TIMEOUT_CYC cycles elapse without ack, irq_timeout pulses for 1 cycle, irq_req/irq_grant/irq_id clear, and the FSM returns to IDLE.
  - pending[irq_id] stays set.
  - rr_ptr = irq_id + 1, so other channels are served before the timed-out one is retried in round-robin mode.
  - The counter resets to 0 on entry to BUSY.
- INTC_TIMEOUT_EN undefined: no counter and no irq_timeout port. BUSY waits indefinitely for ack.

## Test plan
- Reset, N_IRQ = 8, mode = 0, identity table, raise irq_in[5] and irq_in[2] on the same cycle -> irq_id = 2, irq_grant = 8'h04 two cycles later; ack -> next grant irq_id = 5 after one idle cycle.
- Load table with rank 0 = channel 7, then raise irq_in[0] and irq_in[7] -> channel 7 is granted first.
- mode = 1, channels 1, 3 and 6 pending, ack each grant immediately -> grant order 1, 3, 6. Re-raise channel 1 plus channel 0 -> grant 0 (wrap from rr_ptr = 7).
- mask[4] = 1, pulse irq_in[4] -> no irq_req. Clear mask -> irq_id = 4 granted without a new edge.
- During BUSY on channel 3, pulse irq_in[3] in the ack cycle -> channel 3 is granted again after the idle cycle.
- With INTC_TIMEOUT_EN and TIMEOUT_CYC = 10, grant channel 2 and never ack -> irq_timeout pulses 10 cycles after irq_req rose, irq_req drops, and pending[2] remains set.
